seven_seg_capture: RTL and testbench

Reads back a time-multiplexed, active-low 7-segment display bus (segments A–G plus per-digit enables) and recovers the displayed multi-digit hex value. Each digit is qualified for stability, decoded back to its 4-bit nibble, and assembled into a frame word. The block sits on the board-test and loopback side of the display path, so firmware or a bench can confirm what the display driver is actually showing.

---
 rtl/seven_seg_capture.sv | 142 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - recovers a hex frame from a multiplexed active-low 7-segment bus
// Each segment/enable pair is qualified for stability, decoded, and slotted into a frame word.
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_N,
  input  logic [6:0]              i_Segments,
  input  logic [NUM_DIGITS-1:0]   i_Digit_En_N,
  output logic [4*NUM_DIGITS-1:0] o_Value,
  output logic                    o_Valid,
  output logic [NUM_DIGITS-1:0]   o_Err_Mask
);

  localparam int CW = $clog2(STABLE_CYCLES);

  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    same;
  logic [NUM_DIGITS-1:0]   en_act;
  logic                    one_hot;
  logic                    fire;
  logic [6:0]              pat;
  logic [3:0]              dec_nib;
  logic                    dec_err;

  logic                    cap_q;
  logic [NUM_DIGITS-1:0]   cap_sel_q;
  logic [3:0]              cap_nib_q;
  logic                    cap_err_q;

  logic [4*NUM_DIGITS-1:0] slot_nib_q, slot_nib_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    valid_q, valid_d;

  assign same    = (i_Segments == seg_q) && (i_Digit_En_N == en_q);
  assign en_act  = ~en_q;
  assign one_hot = (en_act != '0) && ((en_act & (en_act - NUM_DIGITS'(1))) == '0);
  // Only the single S-2 -> S-1 step fires, so a held pair yields one capture.
  assign fire    = same && (cnt_q == CW'(STABLE_CYCLES - 2)) && one_hot;
  assign pat     = ~seg_q;

  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CW'(STABLE_CYCLES - 1)) ? cnt_q : cnt_q + CW'(1);
    end
  end

  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (pat)
      7'h7E: dec_nib = 4'h0;
      7'h30: dec_nib = 4'h1;
      7'h6D: dec_nib = 4'h2;
      7'h79: dec_nib = 4'h3;
      7'h33: dec_nib = 4'h4;
      7'h5B: dec_nib = 4'h5;
      7'h5F: dec_nib = 4'h6;
      7'h70: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h7B: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h1F: dec_nib = 4'hB;
      7'h4E: dec_nib = 4'hC;
      7'h3D: dec_nib = 4'hD;
      7'h4F: dec_nib = 4'hE;
      7'h47: dec_nib = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_err_d = slot_err_q;
    seen_d     = seen_q;
    value_d    = value_q;
    mask_d     = mask_q;
    valid_d    = 1'b0;
    if (&seen_q) begin
      value_d    = slot_nib_q;
      mask_d     = slot_err_q;
      valid_d    = 1'b1;
      slot_nib_d = '0;
      slot_err_d = '0;
      seen_d     = '0;
    end
    // Applied after the clear so a coincident capture lands in the fresh frame.
    if (cap_q) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_sel_q[i]) begin
          slot_nib_d[4*i +: 4] = cap_nib_q;
          slot_err_d[i]        = cap_err_q;
          seen_d[i]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      seg_q      <= 7'h7F;
      en_q       <= '1;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      cap_sel_q  <= '0;
      cap_nib_q  <= 4'h0;
      cap_err_q  <= 1'b0;
      slot_nib_q <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
      value_q    <= '0;
      mask_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      seg_q      <= i_Segments;
      en_q       <= i_Digit_En_N;
      cnt_q      <= cnt_d;
      cap_q      <= fire;
      cap_sel_q  <= en_act;
      cap_nib_q  <= dec_nib;
      cap_err_q  <= dec_err;
      slot_nib_q <= slot_nib_d;
      slot_err_q <= slot_err_d;
      seen_q     <= seen_d;
      value_q    <= value_d;
      mask_q     <= mask_d;
      valid_q    <= valid_d;
    end
  end

  assign o_Value    = value_q;
  assign o_Valid    = valid_q;
  assign o_Err_Mask = mask_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  en_n;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  err_mask;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vcount = 0;
  int vcyc   = -1;
  int v0;
  int e0;

  logic [6:0] glyph [16];

  seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_Clk        (clk),
    .i_Rst_N      (rst_n),
    .i_Segments   (seg),
    .i_Digit_En_N (en_n),
    .o_Value      (value),
    .o_Valid      (valid),
    .o_Err_Mask   (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (valid) begin
      vcount++;
      vcyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_raw(input logic [3:0] en, input logic [6:0] s, input int n);
    en_n = en;
    seg  = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_digit(input int slot, input int nib, input int n);
    logic [3:0] en;
    en = 4'hF;
    en[slot] = 1'b0;
    drive_raw(en, ~glyph[nib], n);
  endtask

  task automatic blank(input int n);
    drive_raw(4'hF, 7'h7F, n);
  endtask

  initial begin
    glyph[0]  = 7'h7E; glyph[1]  = 7'h30; glyph[2]  = 7'h6D; glyph[3]  = 7'h79;
    glyph[4]  = 7'h33; glyph[5]  = 7'h5B; glyph[6]  = 7'h5F; glyph[7]  = 7'h70;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h7B; glyph[10] = 7'h77; glyph[11] = 7'h1F;
    glyph[12] = 7'h4E; glyph[13] = 7'h3D; glyph[14] = 7'h4F; glyph[15] = 7'h47;

    rst_n = 1'b0;
    seg   = 7'h7F;
    en_n  = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_mask", 32'(err_mask), 32'h0);
    rst_n = 1'b1;
    blank(4);

    // Clean frame: 4,3,2,1 in slots 0..3
    v0 = vcount;
    drive_digit(0, 4, 8);
    drive_digit(1, 3, 8);
    drive_digit(2, 2, 8);
    drive_digit(3, 1, 8);
    blank(4);
    check("clean_valid_count", 32'(vcount - v0), 32'd1);
    check("clean_value", 32'(value), 32'h1234);
    check("clean_mask", 32'(err_mask), 32'h0);

    // Short glitch on slot 2, then a qualifying 4-cycle hold
    v0 = vcount;
    drive_digit(0, 4, 8);
    drive_digit(1, 3, 8);
    drive_digit(3, 1, 8);
    drive_digit(2, 2, 3);
    blank(10);
    check("glitch_no_valid", 32'(vcount - v0), 32'd0);
    e0 = cyc + 1;
    drive_digit(2, 2, 4);
    blank(10);
    check("glitch_valid_count", 32'(vcount - v0), 32'd1);
    check("glitch_valid_timing", 32'(vcyc), 32'(e0 + 5));
    check("glitch_value", 32'(value), 32'h1234);

    // Illegal glyph (all segments off) in slot 2
    v0 = vcount;
    drive_digit(0, 8, 8);
    drive_digit(1, 8, 8);
    drive_raw(4'b1011, 7'h7F, 8);
    drive_digit(3, 8, 8);
    blank(4);
    check("illegal_valid_count", 32'(vcount - v0), 32'd1);
    check("illegal_value", 32'(value), 32'h8088);
    check("illegal_mask", 32'(err_mask), 32'h4);

    // Multi-hot then zero-hot enables
    v0 = vcount;
    drive_raw(4'b1100, ~glyph[5], 20);
    drive_raw(4'b1111, ~glyph[5], 20);
    check("badEn_no_valid", 32'(vcount - v0), 32'd0);
    check("badEn_value_held", 32'(value), 32'h8088);
    check("badEn_mask_held", 32'(err_mask), 32'h4);

    // Reset with slots 0 and 1 captured, then a full frame F,E,D,C
    v0 = vcount;
    drive_digit(0, 3, 8);
    drive_digit(1, 3, 8);
    blank(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_value", 32'(value), 32'h0);
    check("midreset_mask", 32'(err_mask), 32'h0);
    blank(4);
    drive_digit(0, 15, 8);
    drive_digit(1, 14, 8);
    drive_digit(2, 13, 8);
    drive_digit(3, 12, 8);
    blank(4);
    check("midreset_valid_count", 32'(vcount - v0), 32'd1);
    check("midreset_frame_value", 32'(value), 32'hCDEF);

    // Slot 1 overwritten before frame completes
    v0 = vcount;
    drive_digit(1, 5, 8);
    drive_digit(1, 9, 8);
    drive_digit(0, 0, 8);
    drive_digit(2, 0, 8);
    drive_digit(3, 0, 8);
    blank(4);
    check("overwrite_valid_count", 32'(vcount - v0), 32'd1);
    check("overwrite_value", 32'(value), 32'h0090);
    check("overwrite_mask", 32'(err_mask), 32'h0);
    check("valid_idle_low", 32'(valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
